// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if -- instruction memory bus between the fetch stage and imem.
//
// Signals:
//   ImemReq    fetch side -> memory : request valid
//   ImemAddr   fetch side -> memory : request address (32 bit)
//   ImemGnt    memory -> fetch side : request accepted this cycle
//   ImemRValid memory -> fetch side : read data valid (single-cycle strobe)
//   ImemRData  memory -> fetch side : instruction word (32 bit)
//
// Handshake: a request transfers on a rising edge where ImemReq and ImemGnt
// are both high; memory samples ImemAddr only on that cycle, so the address
// may change (or ImemReq may drop) while ungranted. ImemGnt is ignored when
// ImemReq is low. The response is a one-cycle ImemRValid strobe with no
// backpressure; the fetch side must take or drop it on that cycle.
//
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemGnt, ImemRValid, ImemRData
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemGnt, ImemRValid, ImemRData
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch with a single outstanding imem request,
// IF/ID pipeline register, one-entry hold buffer for decode stalls and
// redirect handling with a kill flag for in-flight responses.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  word presented on Instr_ID when no valid instruction
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem              instruction memory bus (fetch_stage_if.master)
//   Stall_IF          no new request, PC holds
//   Stall_ID          IF/ID register holds
//   Redirect_EX       taken branch/jump from EX (wins over stalls)
//   RedirectPC_EX     redirect target
//   Valid_ID, Instr_ID, PC_ID, PCPlus4_ID   IF/ID register to decode
//   state_dbg         current FSM state (IDLE=0, REQ=1, WAIT=2, HOLD=3)
//
// Build option: define FETCH_BACK_TO_BACK_EN to issue the next request in
// the same cycle a response is delivered (1 instr/cycle on zero-wait
// memory). Undefined, the FSM goes back through REQ (1 instr per 2 cycles).
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 Stall_IF,
  input  logic                 Stall_ID,
  input  logic                 Redirect_EX,
  input  logic [31:0]          RedirectPC_EX,
  output logic                 Valid_ID,
  output logic [31:0]          Instr_ID,
  output logic [31:0]          PC_ID,
  output logic [31:0]          PCPlus4_ID,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        rsp_live;
  logic        deliver;
  logic        b2b_req;
  logic        fire;

  // A response that belongs to the current stream (not killed, not being
  // overridden by a redirect this very cycle).
  assign rsp_live = (state == S_WAIT) && imem.ImemRValid && !kill && !Redirect_EX;
  assign deliver  = rsp_live && !Stall_ID;

`ifdef FETCH_BACK_TO_BACK_EN
  assign b2b_req = deliver && !Stall_IF;
`else
  assign b2b_req = 1'b0;
`endif

  assign imem.ImemReq  = ((state == S_REQ) && !Stall_IF) || b2b_req;
  assign imem.ImemAddr = pc;
  assign fire          = imem.ImemReq && imem.ImemGnt;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'h0;
      Valid_ID   <= 1'b0;
      Instr_ID   <= NOP_INSTR;
      PC_ID      <= 32'h0;
      PCPlus4_ID <= 32'h0;
    end else begin
      // PC: redirect target beats sequential advance.
      if (Redirect_EX)
        pc <= RedirectPC_EX;
      else if (fire)
        pc <= pc + 32'd4;

      if (fire)
        req_pc <= pc;

      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (fire) begin
            state <= S_WAIT;
            // Redirect on the grant cycle: the granted fetch is stale.
            kill  <= Redirect_EX;
          end
        end

        S_WAIT: begin
          if (imem.ImemRValid) begin
            if (fire) begin
              // Back-to-back: delivered one response and issued the next.
              state <= S_WAIT;
              kill  <= 1'b0;
            end else if (kill || Redirect_EX) begin
              state <= S_REQ;
              kill  <= 1'b0;
            end else if (Stall_ID) begin
              state      <= S_HOLD;
              hold_instr <= imem.ImemRData;
              hold_pc    <= req_pc;
            end else begin
              state <= S_REQ;
            end
          end else if (Redirect_EX) begin
            kill <= 1'b1;
          end
        end

        S_HOLD: begin
          // Leaving HOLD on redirect simply abandons the buffered word.
          if (Redirect_EX || !Stall_ID)
            state <= S_REQ;
        end

        default: state <= S_IDLE;
      endcase

      // IF/ID register
      if (Redirect_EX) begin
        Valid_ID <= 1'b0;
        Instr_ID <= NOP_INSTR;
      end else if (deliver) begin
        Valid_ID   <= 1'b1;
        Instr_ID   <= imem.ImemRData;
        PC_ID      <= req_pc;
        PCPlus4_ID <= req_pc + 32'd4;
      end else if ((state == S_HOLD) && !Stall_ID) begin
        Valid_ID   <= 1'b1;
        Instr_ID   <= hold_instr;
        PC_ID      <= hold_pc;
        PCPlus4_ID <= hold_pc + 32'd4;
      end else if (!Stall_ID) begin
        Valid_ID <= 1'b0;
        Instr_ID <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // shared hazard inputs
  logic        stall_if;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_stage_if imem0 ();
  fetch_stage_if imem1 ();

  logic        valid0, valid1;
  logic [31:0] instr0, instr1, pc0, pc1, pc4_0, pc4_1;
  logic [1:0]  st0, st1;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem(imem0),
    .Stall_IF(stall_if), .Stall_ID(stall_id),
    .Redirect_EX(redirect), .RedirectPC_EX(redirect_pc),
    .Valid_ID(valid0), .Instr_ID(instr0), .PC_ID(pc0), .PCPlus4_ID(pc4_0),
    .state_dbg(st0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem(imem1),
    .Stall_IF(stall_if), .Stall_ID(stall_id),
    .Redirect_EX(redirect), .RedirectPC_EX(redirect_pc),
    .Valid_ID(valid1), .Instr_ID(instr1), .PC_ID(pc1), .PCPlus4_ID(pc4_1),
    .state_dbg(st1)
  );

  // memory model state: response one cycle after grant, data = address
  logic        pend0, pend1;
  logic [31:0] paddr0, paddr1;
  logic        mem_block;
  logic        force_rv;
  logic [31:0] force_data;
  logic        last_req;
  logic [31:0] last_addr;

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: apply inputs for one cycle, record request seen before the edge,
  // advance one rising edge and update the memory model.
  task automatic cycle(input logic sif, input logic sid, input logic red, input logic [31:0] rpc);
    logic g0, g1, rv0, rv1, forced;
    logic [31:0] a1;
    stall_if    = sif;
    stall_id    = sid;
    redirect    = red;
    redirect_pc = rpc;
    forced      = force_rv;
    rv0 = forced ? 1'b1 : (pend0 && !mem_block);
    imem0.ImemRValid = rv0;
    imem0.ImemRData  = forced ? force_data : paddr0;
    rv1 = pend1;
    imem1.ImemRValid = rv1;
    imem1.ImemRData  = paddr1;
    #1;
    last_req  = imem0.ImemReq;
    last_addr = imem0.ImemAddr;
    g0 = imem0.ImemReq && imem0.ImemGnt;
    g1 = imem1.ImemReq && imem1.ImemGnt;
    a1 = imem1.ImemAddr;
    @(posedge clk);
    #1;
    force_rv = 1'b0;
    if (rv0 && !forced) pend0 = 1'b0;
    if (rv1) pend1 = 1'b0;
    if (g0) begin pend0 = 1'b1; paddr0 = last_addr; end
    if (g1) begin pend1 = 1'b1; paddr1 = a1; end
    if (!rst_n) begin pend0 = 1'b0; pend1 = 1'b0; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic exp_v;
    logic [31:0] e;
    stall_if = 0; stall_id = 0; redirect = 0; redirect_pc = 0;
    imem0.ImemGnt = 1'b1; imem1.ImemGnt = 1'b1;
    imem0.ImemRValid = 0; imem0.ImemRData = 0;
    imem1.ImemRValid = 0; imem1.ImemRData = 0;
    pend0 = 0; pend1 = 0; paddr0 = 0; paddr1 = 0;
    mem_block = 0; force_rv = 0; force_data = 0;
    last_req = 0; last_addr = 0;

    // ---------------- reset values ----------------
    rst_n = 1'b0;
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    check_vec("rst_req",   imem0.ImemReq,  0);
    check_vec("rst_addr",  imem0.ImemAddr, 32'h0);
    check_vec("rst_addr1", imem1.ImemAddr, 32'hFFFF_FFF8);
    check_vec("rst_valid", valid0, 0);
    check_vec("rst_instr", instr0, NOP);
    check_vec("rst_pc",    pc0,    0);
    check_vec("rst_pc4",   pc4_0,  0);
    check_vec("rst_state", st0,    0);
    rst_n = 1'b1;

    // ---------------- streaming, gnt always 1 ----------------
    for (int j = 0; j < 8; j++) exp_q.push_back(32'(j) * 32'd4);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 32'h0);
`ifdef FETCH_BACK_TO_BACK_EN
      exp_v = (i >= 2);
`else
      exp_v = (i >= 2) && (i % 2 == 0);
`endif
      check_vec("stream_valid", valid0, exp_v);
      check_vec("wrap_valid",   valid1, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        check_vec("stream_pc",    pc0,    e);
        check_vec("stream_instr", instr0, e);
        check_vec("stream_pc4",   pc4_0,  e + 32'd4);
        e = 32'hFFFF_FFF8 + 32'(k) * 32'd4;
        check_vec("wrap_pc",  pc1,   e);
        check_vec("wrap_pc4", pc4_1, e + 32'd4);
        if (k == 1) check_vec("wrap_pc4_fffc", pc4_1, 32'h0);
        k++;
      end
    end

    // ---------------- decode+fetch stall with response in flight ----------------
    apply_reset();
    cycle(0, 0, 0, 32'h0);           // IDLE
    cycle(0, 0, 0, 32'h0);           // grant 0
    cycle(1, 0, 0, 32'h0);           // deliver 0
    cycle(0, 0, 0, 32'h0);           // grant 4
    cycle(1, 0, 0, 32'h0);           // deliver 4
    check_vec("pre_pc4", pc0, 32'h4);
    cycle(0, 1, 0, 32'h0);           // grant 8, IF/ID held
    check_vec("stl_hold_v", valid0, 1);
    check_vec("stl_hold_pc", pc0, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 32'h0);
      check_vec("stl_noreq", last_req, 0);
      check_vec("stl_v", valid0, 1);
      check_vec("stl_pc", pc0, 32'h4);
    end
    check_vec("stl_state_hold", st0, 3);
    cycle(0, 0, 0, 32'h0);           // buffer -> IF/ID
    check_vec("unstl_v", valid0, 1);
    check_vec("unstl_pc", pc0, 32'h8);
    check_vec("unstl_instr", instr0, 32'h8);
    cycle(0, 0, 0, 32'h0);
    check_vec("unstl_next_addr", last_addr, 32'hC);
    check_vec("unstl_next_req", last_req, 1);
    cycle(1, 0, 0, 32'h0);
    check_vec("unstl_pc_c", pc0, 32'hC);

    // ---------------- redirect while 0x10 outstanding ----------------
    cycle(0, 1, 0, 32'h0);           // grant 0x10, IF/ID holds C
    check_vec("rd_pre_v", valid0, 1);
    mem_block = 1'b1;
    cycle(0, 1, 1, 32'h100);         // redirect beats Stall_ID
    check_vec("rd_v", valid0, 0);
    check_vec("rd_instr", instr0, NOP);
    mem_block = 1'b0;
    cycle(0, 0, 0, 32'h0);           // late response for 0x10 dropped
    check_vec("rd_drop_v", valid0, 0);
    check_vec("rd_drop_state", st0, 1);
    cycle(0, 0, 0, 32'h0);
    check_vec("rd_addr", last_addr, 32'h100);
    check_vec("rd_req", last_req, 1);
    cycle(1, 0, 0, 32'h0);
    check_vec("rd_pc", pc0, 32'h100);
    check_vec("rd_new_instr", instr0, 32'h100);

    // ---------------- redirect + Stall_ID in HOLD ----------------
    cycle(0, 0, 0, 32'h0);           // grant 0x104
    cycle(1, 1, 0, 32'h0);           // response buffered
    check_vec("hold_state", st0, 3);
    cycle(1, 1, 1, 32'h100);
    check_vec("hrd_v", valid0, 0);
    check_vec("hrd_state", st0, 1);
    cycle(0, 0, 0, 32'h0);
    check_vec("hrd_addr", last_addr, 32'h100);
    check_vec("hrd_nobuf_v", valid0, 0);
    cycle(1, 0, 0, 32'h0);
    check_vec("hrd_pc", pc0, 32'h100);

    // ---------------- redirect coincident with RValid ----------------
    cycle(0, 0, 0, 32'h0);           // grant 0x104
    cycle(1, 0, 1, 32'h300);
    check_vec("crd_v", valid0, 0);
    check_vec("crd_state", st0, 1);
    cycle(0, 0, 0, 32'h0);
    check_vec("crd_addr", last_addr, 32'h300);
    cycle(1, 0, 0, 32'h0);
    check_vec("crd_v2", valid0, 1);
    check_vec("crd_pc", pc0, 32'h300);

    // ---------------- RValid outside WAIT ----------------
    force_rv = 1'b1; force_data = 32'hDEAD_BEEF;
    cycle(1, 0, 0, 32'h0);
    check_vec("stray_state", st0, 1);
    check_vec("stray_v", valid0, 0);
    cycle(0, 0, 0, 32'h0);
    check_vec("stray_addr", last_addr, 32'h304);
    check_vec("stray_wait", st0, 2);

    // ---------------- reset during WAIT, late RValid ----------------
    mem_block = 1'b1;
    rst_n = 1'b0;
    #1;
    check_vec("mrst_state", st0, 0);
    check_vec("mrst_req", imem0.ImemReq, 0);
    check_vec("mrst_addr", imem0.ImemAddr, 32'h0);
    check_vec("mrst_v", valid0, 0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    rst_n = 1'b1;
    mem_block = 1'b0;
    force_rv = 1'b1; force_data = 32'h0000_BAD0;
    cycle(0, 0, 0, 32'h0);           // IDLE, pulse ignored
    check_vec("late_v", valid0, 0);
    check_vec("late_state", st0, 1);
    cycle(0, 0, 0, 32'h0);
    check_vec("late_req", last_req, 1);
    check_vec("late_addr", last_addr, 32'h0);
    cycle(1, 0, 0, 32'h0);
    check_vec("late_pc", pc0, 32'h0);
    check_vec("late_instr", instr0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, value driven on Instr_ID when no valid instruction is present.
REQ-003 clk  in  1  single clock; one clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Stall_IF  in  1  hazard-unit stall of fetch: no new request, PC holds.
REQ-006 Stall_ID  in  1  hazard-unit stall of decode: IF/ID register holds.
REQ-007 Redirect_EX  in  1  taken branch/jump resolved in EX.
REQ-008 RedirectPC_EX  in  32  redirect target.
REQ-009 ImemReq  out  1  fetch request; ImemAddr  out  32  request address.
REQ-010 ImemGnt  in  1  memory accepted request this cycle (meaningful only with ImemReq=1).
REQ-011 ImemRValid  in  1  read data valid; ImemRData  in  32  instruction word.
REQ-012 Valid_ID, Instr_ID[31:0], PC_ID[31:0], PCPlus4_ID[31:0]  out  IF/ID pipeline register to decode.

Function
REQ-013 SHALL keep at most one outstanding memory request.
REQ-014 FSM states: IDLE (one cycle after reset release), REQ (requesting), WAIT (granted, awaiting RValid), HOLD (response buffered while Stall_ID); IDLE->REQ unconditionally.
REQ-015 ImemReq = (state==REQ) & !Stall_IF; ImemAddr = PC register; address may change while ImemReq=1 without ImemGnt; memory samples only on grant cycle.
REQ-016 On ImemReq & ImemGnt: ReqPC <= PC, PC <= PC+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), REQ->WAIT.
REQ-017 In WAIT on ImemRValid, not killed, Stall_ID=0: IF/ID <= {1, ImemRData, ReqPC, ReqPC+4}, WAIT->REQ.
REQ-018 In WAIT on ImemRValid, not killed, Stall_ID=1: word and ReqPC captured in hold buffer, WAIT->HOLD, IF/ID unchanged.
REQ-019 In HOLD with Stall_ID=0: IF/ID <= buffer contents, Valid_ID=1, HOLD->REQ; with Stall_ID=1 remain HOLD.
REQ-020 Stall_ID=1 and no redirect: IF/ID holds all fields; Stall_ID=0 and no instruction delivered: Valid_ID <= 0, Instr_ID <= NOP_INSTR.
REQ-021 Redirect_EX=1 has priority over all stalls: PC <= RedirectPC_EX, Valid_ID <= 0, Instr_ID <= NOP_INSTR, hold buffer discarded, state -> REQ unless a request is outstanding.
REQ-022 Redirect in WAIT, or coincident with a grant: kill flag set, state WAIT; the response, when it arrives, is dropped and kill cleared, state -> REQ.
REQ-023 Redirect coincident with ImemRValid: response dropped, no kill flag left set.
REQ-024 ImemRValid outside WAIT SHALL be ignored.

Reset
REQ-025 While rst_n=0: state IDLE, PC=RESET_PC, ImemReq=0, ImemAddr=RESET_PC, kill=0, Valid_ID=0, Instr_ID=NOP_INSTR, PC_ID=0, PCPlus4_ID=0, hold buffer empty.
REQ-026 Reset asserted mid-transaction SHALL abandon it; a late ImemRValid after release is ignored (state not WAIT).

Configuration
REQ-027 Macro FETCH_BACK_TO_BACK_EN defined: in the cycle a response is delivered to IF/ID (REQ-017) with Stall_IF=0, ImemReq SHALL also assert for PC; zero-wait memory sustains 1 instr/cycle.
REQ-028 Macro undefined: no request in a delivery cycle; state passes through REQ first; zero-wait memory yields 1 instr per 2 cycles.

Verification
REQ-029 Reset release, Gnt always 1, RValid 1 cycle after grant, data=addr: Valid_ID stream PC_ID 0,4,8,...; with macro consecutive cycles, without macro every other cycle.
REQ-030 Stall_ID=Stall_IF=1 for 3 cycles while response for 0x8 arrives: IF/ID holds 0x4 for 3 cycles, then PC_ID=0x8, no request during stall, no instruction lost or duplicated.
REQ-031 Redirect_EX=1, RedirectPC_EX=0x100 while request 0x10 outstanding: response for 0x10 dropped, Valid_ID=0 next cycle, next ImemAddr granted=0x100, next PC_ID=0x100.
REQ-032 Redirect and Stall_ID asserted same cycle in HOLD: Valid_ID=0 next cycle, buffer discarded, next fetch 0x100.
REQ-033 RESET_PC=32'hFFFF_FFF8: fetched PC_ID sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4_ID of FFFF_FFFC = 0000_0000.
REQ-034 rst_n low while in WAIT, RValid pulses 1 cycle after release: pulse ignored, first request at RESET_PC.
